// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream boot loader that fills instruction memory and releases the CPU
module imem_boot_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              restart_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_run_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        DEPTH_B   = 8'(DEPTH);
    localparam logic [ADDR_W:0]   ONE       = (ADDR_W + 1)'(1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] idx, idx_d;
    logic [ADDR_W:0]   nwords, nwords_d;
    logic [1:0]        bcnt, bcnt_d;
    logic [23:0]       shreg, shreg_d;
    logic [7:0]        csum, csum_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic              acc;
    logic              last_word;

    // byte_ready_o is registered from the next state, so it already reflects the current state
    assign acc       = byte_valid_i & byte_ready_o;
    assign last_word = ({1'b0, idx} == (nwords - ONE));

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        nwords_d = nwords;
        bcnt_d   = bcnt;
        shreg_d  = shreg;
        csum_d   = csum;
        we_d     = 1'b0;
        addr_d   = im_addr_o;
        wdata_d  = im_wdata_o;
        case (state)
            CLEAR: begin
                we_d    = 1'b1;
                addr_d  = idx;
                wdata_d = 32'd0;
                if (idx == LAST_ADDR) begin
                    state_d = HDR;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            HDR: begin
                if (acc) begin
                    if (byte_i == 8'd0 || byte_i > DEPTH_B) begin
                        state_d = ERR;
                    end else begin
                        state_d  = DATA;
                        nwords_d = byte_i[ADDR_W:0];
                        idx_d    = '0;
                        bcnt_d   = '0;
                        csum_d   = '0;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    csum_d  = csum ^ byte_i;
                    bcnt_d  = bcnt + 1'b1;
                    shreg_d = {shreg[15:0], byte_i};
                    if (bcnt == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx;
                        wdata_d = {shreg, byte_i};
                        if (last_word) begin
                            state_d = CSUM;
                        end else begin
                            idx_d = idx + 1'b1;
                        end
                    end
                end
            end
            CSUM: begin
                if (acc) begin
                    state_d = (byte_i == csum) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (restart_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= CLEAR;
            idx          <= '0;
            nwords       <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            csum         <= '0;
            im_we_o      <= 1'b0;
            im_addr_o    <= '0;
            im_wdata_o   <= '0;
            byte_ready_o <= 1'b0;
            cpu_run_o    <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            nwords       <= nwords_d;
            bcnt         <= bcnt_d;
            shreg        <= shreg_d;
            csum         <= csum_d;
            im_we_o      <= we_d;
            im_addr_o    <= addr_d;
            im_wdata_o   <= wdata_d;
            byte_ready_o <= (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
            cpu_run_o    <= (state_d == DONE);
            done_o       <= (state_d == DONE);
            err_o        <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed bench for imem_boot_loader
module tb_imem_boot_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        restart_i = 1'b0;
    logic        im_we_o;
    logic [4:0]  im_addr_o;
    logic [31:0] im_wdata_o;
    logic        cpu_run_o;
    logic        done_o;
    logic        err_o;

    int tests  = 0;
    int failed = 0;
    int wr_count = 0;
    logic [31:0] tb_mem [32];
    logic [4:0]  last_wr_addr;

    imem_boot_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .restart_i    (restart_i),
        .im_we_o      (im_we_o),
        .im_addr_o    (im_addr_o),
        .im_wdata_o   (im_wdata_o),
        .cpu_run_o    (cpu_run_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // one clock; outputs sampled 1 ns after the edge and any write is logged
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (im_we_o === 1'b1) begin
            tb_mem[im_addr_o] = im_wdata_o;
            last_wr_addr = im_addr_o;
            wr_count++;
        end
    endtask

    task automatic run_clear();
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("clr_we[%0d]", i), {31'd0, im_we_o}, 32'd1);
            check($sformatf("clr_addr[%0d]", i), {27'd0, im_addr_o}, i);
            check($sformatf("clr_data[%0d]", i), im_wdata_o, 32'd0);
            check($sformatf("clr_rdy[%0d]", i), {31'd0, byte_ready_o}, (i == 31) ? 32'd1 : 32'd0);
        end
        wr_count = 0;
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        int n;
        byte_i = b;
        byte_valid_i = 1'b1;
        n = 0;
        do begin
            r = byte_ready_o;
            tick();
            n++;
        end while (!r && n < 50);
        if (!r) begin
            tests++;
            failed++;
            $error("FAIL send_timeout: byte %h not accepted", b);
        end
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        byte_valid_i = 1'b0;
        tick();
    endtask

    task automatic send_prog(input logic [7:0] cs, input bit gap);
        logic [7:0] bytes [10];
        bytes = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04, 8'h00};
        bytes[9] = cs;
        for (int i = 0; i < 10; i++) begin
            if (gap) send_gap(bytes[i]);
            else     send(bytes[i]);
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic pulse_restart();
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        check("rst_run", {31'd0, cpu_run_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        restart_i = 1'b0;
        tick();
        tick();
        check("reset_outs", {24'd0, im_we_o, im_addr_o, byte_ready_o, cpu_run_o},
              32'd0);
        check("reset_flags", {30'd0, done_o, err_o}, 32'd0);
        check("reset_wdata", im_wdata_o, 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        // 1: reset, clear phase
        do_reset();
        run_clear();

        // 2: good program; checksum is the XOR of the eight data bytes (0xAE)
        send_prog(8'hAE, 1'b0);
        check("s2_w0", tb_mem[0], 32'h20010005);
        check("s2_w1", tb_mem[1], 32'h8C020004);
        check("s2_wcnt", wr_count, 32'd2);
        check("s2_done", {31'd0, done_o}, 32'd1);
        check("s2_run", {31'd0, cpu_run_o}, 32'd1);
        check("s2_err", {31'd0, err_o}, 32'd0);
        check("s2_rdy", {31'd0, byte_ready_o}, 32'd0);
        byte_i = 8'h55;
        byte_valid_i = 1'b1;
        tick();
        tick();
        byte_valid_i = 1'b0;
        check("s2_hold", {30'd0, done_o, cpu_run_o}, 32'd3);

        // 3: bad checksum, then restart
        pulse_restart();
        run_clear();
        send_prog(8'h00, 1'b0);
        check("s3_w0", tb_mem[0], 32'h20010005);
        check("s3_w1", tb_mem[1], 32'h8C020004);
        check("s3_wcnt", wr_count, 32'd2);
        check("s3_err", {31'd0, err_o}, 32'd1);
        check("s3_run", {31'd0, cpu_run_o}, 32'd0);
        check("s3_done", {31'd0, done_o}, 32'd0);
        pulse_restart();
        run_clear();

        // 4: bad headers
        send(8'h00);
        check("s4a_err", {31'd0, err_o}, 32'd1);
        byte_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        byte_valid_i = 1'b0;
        check("s4a_wcnt", wr_count, 32'd0);
        check("s4a_rdy", {31'd0, byte_ready_o}, 32'd0);
        pulse_restart();
        run_clear();
        send(8'h21);
        check("s4b_err", {31'd0, err_o}, 32'd1);
        check("s4b_wcnt", wr_count, 32'd0);
        pulse_restart();
        run_clear();
        send(8'h20);
        byte_valid_i = 1'b0;
        check("s4c_err", {31'd0, err_o}, 32'd0);
        check("s4c_rdy", {31'd0, byte_ready_o}, 32'd1);

        // 5: gapped valid
        do_reset();
        run_clear();
        send_prog(8'hAE, 1'b1);
        check("s5_w0", tb_mem[0], 32'h20010005);
        check("s5_w1", tb_mem[1], 32'h8C020004);
        check("s5_wcnt", wr_count, 32'd2);
        check("s5_done", {31'd0, done_o}, 32'd1);
        check("s5_run", {31'd0, cpu_run_o}, 32'd1);

        // 6: reset after six data bytes
        do_reset();
        run_clear();
        tb_mem[1] = 32'hDEADBEEF;
        send(8'h02);
        send(8'h20); send(8'h01); send(8'h00); send(8'h05);
        send(8'h8C); send(8'h02);
        byte_valid_i = 1'b0;
        check("s6_wcnt", wr_count, 32'd1);
        check("s6_waddr", {27'd0, last_wr_addr}, 32'd0);
        do_reset();
        check("s6_nowrite", tb_mem[1], 32'hDEADBEEF);
        tick();
        check("s6_clr_we", {31'd0, im_we_o}, 32'd1);
        check("s6_clr_addr", {27'd0, im_addr_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
